// File: rtl/pio_link_phy_if.sv
// Pin-side and core-side signal bundle for pio_link_phy.
// cal_req exists only when PIO_LINK_RECAL_EN is defined.
interface pio_link_phy_if #(
    parameter int IO_BITS = 2
);
    logic [IO_BITS-1:0] rx_pins;
    logic [IO_BITS-1:0] tx_pins;
    logic [IO_BITS-1:0] core_tx;
    logic [IO_BITS-1:0] core_rx;
    logic               link_ready;
`ifdef PIO_LINK_RECAL_EN
    logic               cal_req;

    modport slave (
        input  rx_pins, core_tx, cal_req,
        output tx_pins, core_rx, link_ready
    );
    modport master (
        output rx_pins, core_tx, cal_req,
        input  tx_pins, core_rx, link_ready
    );
`else
    modport slave (
        input  rx_pins, core_tx,
        output tx_pins, core_rx, link_ready
    );
    modport master (
        output rx_pins, core_tx,
        input  tx_pins, core_rx, link_ready
    );
`endif
endinterface

// File: rtl/pio_link_phy.sv
// Pin front end for the PIO RAM emulator link: rx sync chain, tx output pipeline and
// loopback -> quiet -> run calibration FSM. Optional recalibration via PIO_LINK_RECAL_EN.
module pio_link_phy #(
    parameter int IO_BITS         = 2,
    parameter int IN_STAGES       = 2,
    parameter int OUT_STAGES      = 1,
    parameter int LOOPBACK_CYCLES = 256,
    parameter int QUIET_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               reset,
    pio_link_phy_if.slave      link
);
    localparam int MAX_CYC = (LOOPBACK_CYCLES > QUIET_CYCLES) ? LOOPBACK_CYCLES : QUIET_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] LB_LAST    = CNT_W'(LOOPBACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOOPBACK = 2'd0,
        ST_QUIET    = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               link_ready_q, link_ready_d;
    logic [IO_BITS-1:0] rx_sync_q [IN_STAGES];
    logic [IO_BITS-1:0] rx_sync_d [IN_STAGES];
    logic [IO_BITS-1:0] tx_pipe_q [OUT_STAGES];
    logic [IO_BITS-1:0] tx_pipe_d [OUT_STAGES];
    logic [IO_BITS-1:0] rx_sync;
    logic [IO_BITS-1:0] tx_src;
    logic               cal_hit;

`ifdef PIO_LINK_RECAL_EN
    assign cal_hit = link.cal_req;
`else
    assign cal_hit = 1'b0;
`endif

    assign rx_sync = rx_sync_q[IN_STAGES-1];

    always_comb begin
        rx_sync_d[0] = link.rx_pins;
        for (int i = 1; i < IN_STAGES; i++) begin
            rx_sync_d[i] = rx_sync_q[i-1];
        end
    end

    // Counter only advances in the timed states and is cleared on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOOPBACK: begin
                if (cnt_q == LB_LAST) begin
                    state_d = ST_QUIET;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (cal_hit) begin
                    state_d = ST_LOOPBACK;
                end
            end
            default: begin
                state_d = ST_LOOPBACK;
                cnt_d   = '0;
            end
        endcase
        link_ready_d = (state_d == ST_RUN);
    end

    always_comb begin
        case (state_q)
            ST_LOOPBACK: tx_src = rx_sync;
            ST_RUN:      tx_src = link.core_tx;
            default:     tx_src = '0;
        endcase
        tx_pipe_d[0] = tx_src;
        for (int i = 1; i < OUT_STAGES; i++) begin
            tx_pipe_d[i] = tx_pipe_q[i-1];
        end
    end

    // Pipeline is never flushed on state changes; loopback data drains naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOOPBACK;
            cnt_q        <= '0;
            link_ready_q <= 1'b0;
            for (int i = 0; i < IN_STAGES; i++) begin
                rx_sync_q[i] <= '0;
            end
            for (int i = 0; i < OUT_STAGES; i++) begin
                tx_pipe_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            link_ready_q <= link_ready_d;
            for (int i = 0; i < IN_STAGES; i++) begin
                rx_sync_q[i] <= rx_sync_d[i];
            end
            for (int i = 0; i < OUT_STAGES; i++) begin
                tx_pipe_q[i] <= tx_pipe_d[i];
            end
        end
    end

    assign link.tx_pins    = tx_pipe_q[OUT_STAGES-1];
    assign link.core_rx    = (state_q == ST_RUN) ? rx_sync : '0;
    assign link.link_ready = link_ready_q;

endmodule
